// File: rtl/mem_log_pkg.sv
// Shared constants for the multi-channel capture logger: FSM encoding and read-path sizing.
package mem_log_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE  = 2'd1;
  localparam logic [1:0] POST = 2'd2;
  localparam logic [1:0] FULL = 2'd3;

  localparam int RD_LAT = 2;
  localparam int OUT_W  = 32;
endpackage

// File: rtl/mem_log_bram.sv
// Simple dual-port BRAM: one write port, one registered read port, read-first on collisions.
module mem_log_bram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Separate block with NBA gives old data on a same-address collision.
  always_ff @(posedge clk)
    if (re) rdata <= mem[raddr];
endmodule

// File: rtl/mem_log_mc.sv
// Multi-channel pre/post-trigger capture logger with a 2-cycle per-channel host read path.
// Optional MEM_LOG_DECIM_EN adds i_decim: write every (i_decim+1)-th valid sample.
module mem_log_mc
  import mem_log_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int NUM_CH          = 2,
  parameter int PRE_TRIG        = 2**(BRAM_ADDR_WIDTH-2),
  parameter int CH_SEL_WIDTH    = 1
) (
  input  logic                              clk,
  input  logic                              i_rst,
  input  logic [NUM_CH*BRAM_DATA_WIDTH-1:0] i_filter_data,
  input  logic                              i_data_valid,
  input  logic                              i_run_log,
  input  logic                              i_trigger,
  input  logic                              i_read_log,
  input  logic [BRAM_ADDR_WIDTH-1:0]        i_addr_log_to_mem,
  input  logic [CH_SEL_WIDTH-1:0]           i_ch_sel,
`ifdef MEM_LOG_DECIM_EN
  input  logic [7:0]                        i_decim,
`endif
  output logic                              o_mem_full,
  output logic                              o_armed,
  output logic [BRAM_ADDR_WIDTH-1:0]        o_start_addr,
  output logic [OUT_W-1:0]                  o_data_log_from_mem
);
  localparam int AW     = BRAM_ADDR_WIDTH;
  localparam int DW     = BRAM_DATA_WIDTH;
  localparam int DEPTH  = 2**AW;
  localparam int STAGES = RD_LAT-1;

  logic [1:0]    state, state_nx;
  logic [AW-1:0] wr_ptr, pre_cnt, start;
  logic [AW:0]   post_cnt;
  logic          tick, wr_en, arm, capturing;

  assign capturing    = (state == PRE) || (state == POST);
  assign arm          = i_run_log && ((state == IDLE) || (state == FULL));
  assign wr_en        = capturing && i_data_valid && tick;
  assign o_start_addr = start;

`ifdef MEM_LOG_DECIM_EN
  logic [7:0] decim_q, dec_cnt;
  assign tick = (dec_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      decim_q <= '0;
      dec_cnt <= '0;
    end else if (arm) begin
      decim_q <= i_decim;
      dec_cnt <= '0;
    end else if (capturing && i_data_valid) begin
      dec_cnt <= (dec_cnt == decim_q) ? 8'd0 : dec_cnt + 8'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FULL: if (i_run_log) state_nx = PRE;
      // A sample landing in the trigger cycle already counts as post-trigger.
      PRE:  if (i_trigger) state_nx = (wr_en && pre_cnt == AW'(DEPTH-1)) ? FULL : POST;
      POST: if (wr_en && post_cnt == (AW+1)'(1)) state_nx = FULL;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      start      <= '0;
      o_armed    <= 1'b0;
      o_mem_full <= 1'b0;
    end else begin
      state      <= state_nx;
      o_armed    <= (state_nx == PRE) || (state_nx == POST);
      o_mem_full <= (state_nx == FULL);
      if (arm) begin
        wr_ptr  <= '0;
        pre_cnt <= '0;
      end
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (state == PRE) begin
        if (i_trigger) begin
          start    <= wr_ptr - pre_cnt;
          post_cnt <= (AW+1)'(DEPTH) - {1'b0, pre_cnt} - {{AW{1'b0}}, wr_en};
        end else if (wr_en && pre_cnt != AW'(PRE_TRIG)) begin
          pre_cnt <= pre_cnt + AW'(1);
        end
      end
      if (state == POST && wr_en) post_cnt <= post_cnt - (AW+1)'(1);
    end
  end

  // Read path: address/channel stage, BRAM register stage, output stage.
  logic [STAGES:0]                   vld_pipe;
  logic [STAGES:0][CH_SEL_WIDTH-1:0] ch_pipe;
  logic [AW-1:0]                     rd_addr;
  logic [NUM_CH*DW-1:0]              rdata;
  logic [NUM_CH-1:0][DW-1:0]         lanes;
  logic [DW-1:0]                     sel;

  mem_log_bram #(.ADDR_W(AW), .DATA_W(NUM_CH*DW)) u_bram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (i_filter_data),
    .re    (vld_pipe[0]),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign lanes[c] = rdata[c*DW +: DW];
  end

  // Unpopulated channel selects fall through to zero.
  always_comb begin
    sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch_pipe[STAGES] == CH_SEL_WIDTH'(c)) sel = lanes[c];
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      vld_pipe            <= '0;
      ch_pipe             <= '0;
      rd_addr             <= '0;
      o_data_log_from_mem <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], i_read_log};
      ch_pipe  <= {ch_pipe[STAGES-1:0], i_ch_sel};
      if (i_read_log) rd_addr <= start + i_addr_log_to_mem;
      if (vld_pipe[STAGES]) o_data_log_from_mem <= OUT_W'(sel);
    end
  end
endmodule

// File: tb/tb_mem_log_mc.sv
// Randomized scoreboard bench for mem_log_mc: the model treats a capture as "the last DEPTH writes".
module tb_mem_log_mc;
  localparam int AW = 4, DW = 16, NCH = 2, PT = 4, CHW = 2;
  localparam int DEPTH = 2**AW;

  logic             clk = 1'b0;
  logic             i_rst, i_data_valid, i_run_log, i_trigger, i_read_log;
  logic [NCH*DW-1:0] i_filter_data;
  logic [AW-1:0]    i_addr_log_to_mem;
  logic [CHW-1:0]   i_ch_sel;
`ifdef MEM_LOG_DECIM_EN
  logic [7:0]       i_decim;
`endif
  logic             o_mem_full, o_armed;
  logic [AW-1:0]    o_start_addr;
  logic [31:0]      o_data_log_from_mem;

  mem_log_mc #(
    .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .NUM_CH(NCH),
    .PRE_TRIG(PT), .CH_SEL_WIDTH(CHW)
  ) dut (
    .clk                 (clk),
    .i_rst               (i_rst),
    .i_filter_data       (i_filter_data),
    .i_data_valid        (i_data_valid),
    .i_run_log           (i_run_log),
    .i_trigger           (i_trigger),
    .i_read_log          (i_read_log),
    .i_addr_log_to_mem   (i_addr_log_to_mem),
    .i_ch_sel            (i_ch_sel),
`ifdef MEM_LOG_DECIM_EN
    .i_decim             (i_decim),
`endif
    .o_mem_full          (o_mem_full),
    .o_armed             (o_armed),
    .o_start_addr        (o_start_addr),
    .o_data_log_from_mem (o_data_log_from_mem)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0;
  logic [31:0] logq[$];
  logic [31:0] expq[$];
  logic [31:0] last_exp = '0;
  logic [15:0] base = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One capture. abort_post >= 0 resets the block after that many post-trigger writes.
  task automatic capture(input int n_pre, input bit all_valid, input int abort_post, input int d);
    logic [31:0] wq[$];
    logic [31:0] w;
    logic [15:0] sval;
    int vc, pre_w, post_w, need, kept, exp_start;
    bit v, wr, first;
    sval = base;
    i_run_log = 1'b1; i_trigger = 1'b1; i_data_valid = 1'b1; i_filter_data = 32'hdead_beef;
`ifdef MEM_LOG_DECIM_EN
    i_decim = 8'(d);
`endif
    step();
    check("armed_after_arm", 32'(o_armed), 32'd1);
    check("full_after_arm", 32'(o_mem_full), 32'd0);
    i_run_log = 1'b0; i_trigger = 1'b0;
    vc = 0; pre_w = 0;
    while (pre_w < n_pre) begin
      v = all_valid || ($urandom_range(0, 1) == 1);
      w = {sval + 16'h100, sval};
      i_data_valid = v; i_filter_data = w;
      step();
      if (v) begin
        wr = (vc % (d + 1)) == 0;
        vc++; sval++;
        if (wr) begin wq.push_back(w); pre_w++; end
      end
    end
    kept = (n_pre < PT) ? n_pre : PT;
    need = DEPTH - kept;
    exp_start = (n_pre - kept) % DEPTH;
    post_w = 0; first = 1'b1;
    while (post_w < need) begin
      v = all_valid || ($urandom_range(0, 1) == 1);
      w = {sval + 16'h100, sval};
      i_data_valid = v; i_filter_data = w;
      i_trigger = first || ($urandom_range(0, 1) == 1);
      first = 1'b0;
      step();
      if (v) begin
        wr = (vc % (d + 1)) == 0;
        vc++; sval++;
        if (wr) begin wq.push_back(w); post_w++; end
      end
      if (post_w < need) check("full_early", 32'(o_mem_full), 32'd0);
      if (abort_post >= 0 && post_w == abort_post) begin
        i_rst = 1'b1; i_data_valid = 1'b0; i_trigger = 1'b0;
        step();
        i_rst = 1'b0;
        check("rst_full", 32'(o_mem_full), 32'd0);
        check("rst_armed", 32'(o_armed), 32'd0);
        check("rst_start", 32'(o_start_addr), 32'd0);
        check("rst_data", o_data_log_from_mem, 32'd0);
        return;
      end
    end
    i_data_valid = 1'b0; i_trigger = 1'b0;
    check("full_done", 32'(o_mem_full), 32'd1);
    check("armed_done", 32'(o_armed), 32'd0);
    check("start_addr", 32'(o_start_addr), 32'(exp_start));
    logq.delete();
    for (int i = wq.size() - DEPTH; i < wq.size(); i++) logq.push_back(wq[i]);
    base = sval;
  endtask

  task automatic read_at(input int a, input int ch);
    logic [31:0] w;
    i_read_log = 1'b1; i_addr_log_to_mem = AW'(a); i_ch_sel = CHW'(ch);
    w = logq[a];
    expq.push_back(ch < NCH ? 32'(w[ch*DW +: DW]) : 32'd0);
    step();
  endtask

  task automatic read_idle();
    i_read_log = 1'b0;
    repeat (4) step();
    check("rd_hold", o_data_log_from_mem, last_exp);
  endtask

  // Monitor: a read sampled at edge k is presented after edge k+2.
  initial begin
    logic [2:0] h;
    h = '0;
    forever begin
      @(posedge clk);
      h = {h[1:0], i_read_log === 1'b1};
      if (h[2]) begin
        #1;
        if (expq.size() == 0) begin
          n_chk++;
          $display("FAIL rd_unexpected: got %h with no expected read", o_data_log_from_mem);
        end else begin
          last_exp = expq.pop_front();
          check("rd_data", o_data_log_from_mem, last_exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: timeout with %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_data_valid = 1'b0; i_run_log = 1'b0; i_trigger = 1'b0;
    i_read_log = 1'b0; i_filter_data = '0; i_addr_log_to_mem = '0; i_ch_sel = '0;
`ifdef MEM_LOG_DECIM_EN
    i_decim = '0;
`endif
    repeat (3) step();
    i_rst = 1'b0;
    step();
    check("reset_full", 32'(o_mem_full), 32'd0);
    check("reset_armed", 32'(o_armed), 32'd0);
    check("reset_start", 32'(o_start_addr), 32'd0);
    check("reset_data", o_data_log_from_mem, 32'd0);

    // Straight fill: trigger on the first PRE cycle, no pre-history.
    base = 16'd0;
    capture(0, 1'b1, -1, 0);
    read_at(5, 1);
    for (int a = 0; a < DEPTH; a++) read_at(a, $urandom_range(0, 3));
    read_idle();

    // Pre-trigger window: 20 pre writes, saturated history of 4.
    base = 16'd0;
    capture(20, 1'b1, -1, 0);
    read_at(0, 0);
    read_at(4, 0);
    read_at(15, 3);
    read_idle();

    // Short pre-history with random valid gaps.
    base = 16'($urandom);
    capture(2, 1'b0, -1, 0);
    for (int a = 0; a < DEPTH; a++) read_at(a, $urandom_range(0, 2));
    read_idle();

    for (int r = 0; r < 3; r++) begin
      base = 16'($urandom);
      capture($urandom_range(0, 25), 1'b0, -1, 0);
      for (int i = 0; i < 8; i++) read_at($urandom_range(0, DEPTH-1), $urandom_range(0, 3));
      read_idle();
    end

    // Mid-capture reset with a non-zero start, then re-arm.
    capture(5, 1'b0, 7, 0);
    base = 16'($urandom);
    capture(3, 1'b0, -1, 0);
    for (int a = 0; a < DEPTH; a++) read_at(a, a % 2);
    read_idle();

`ifdef MEM_LOG_DECIM_EN
    base = 16'd0;
    capture(0, 1'b1, -1, 2);
    for (int a = 0; a < DEPTH; a++) read_at(a, 0);
    read_idle();
`endif

    repeat (4) step();
    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
